pc_redirect_unit: RTL
=====================

# pc_redirect_unit

Parametrised program counter for stage 3 that replaces the fixed-width single-mode PC. It holds the fetch address and its +4 successor, and redirects on PC-relative jumps, register-indirect jumps and traps. It registers a one-cycle flush request and a misaligned-target fault. It optionally carries a circular return-address stack that tracks call/return hints for fetch prediction.

## Interface
Parameters:
- XLEN, 32, address/data width in bits (≥ 8).
- BOOT_ADDR, 32'h0000_0000, reset value of instruction_addr (XLEN bits).
- RAS_DEPTH, 8, return-address stack entries (power of two, ≥ 2).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- stall  in  1  hold all state this cycle (trap excepted).
- valid  in  1  qualifies jump/jalr/is_call/is_return.
- jump  in  1  PC-relative redirect.
- jalr  in  1  absolute redirect.
- jump_offset  in  XLEN  offset for jump, absolute target for jalr.
- trap  in  1  unconditional redirect to trap_vector.
- trap_vector  in  XLEN  trap target, used as-is.
- is_call  in  1  push link_addr (RAS_EN only).
- is_return  in  1  pop (RAS_EN only).
- link_addr  in  XLEN  return address to push.
- instruction_addr  out  XLEN  current fetch address.
- ia_plus4  out  XLEN  instruction_addr + 4, registered.
- do_flush  out  1  registered flush request.
- misaligned  out  1  registered fault pulse.
- ras_top  out  XLEN  top-of-stack prediction.
- ras_empty  out  1  stack holds no entries.

## Operation
- Next-PC priority: reset > trap > (stall: hold) > valid&jump > valid&jalr > sequential.
- jump target = instruction_addr + jump_offset, modulo 2^XLEN.
- jalr target = jump_offset with bit 0 cleared.
- Sequential target = instruction_addr + 4, wrapping modulo 2^XLEN.
- Misalignment: a jump or jalr target with bit 1 set is not taken. The PC loads trap_vector instead, and misaligned and do_flush are both set.
- trap loads trap_vector and sets do_flush, even when stall is high.
- do_flush = 1 after any redirect, 0 after a sequential step. It is held while stalled.
- ia_plus4 is always loaded as next instruction_addr + 4, so it stays consistent with instruction_addr.
- RAS state: RAS_DEPTH entries, a top pointer, and a count saturating at RAS_DEPTH.
- Push: write to top+1 (wrapping) and advance top. When full, the oldest entry is overwritten and count stays at RAS_DEPTH.
- Pop: only when count > 0; retreat top and decrement count. A pop on an empty stack is a no-op.
- Push and pop in the same cycle: the top entry is replaced by link_addr; count and pointer are unchanged.
- RAS updates require valid & !stall & !trap.
- ras_top shows the entry at top when non-empty, 0 when empty.

## Timing
- Reset values: instruction_addr = BOOT_ADDR, ia_plus4 = BOOT_ADDR+4, do_flush = 0, misaligned = 0, RAS count = 0, ras_empty = 1, ras_top = 0.
- Redirect latency is 1 cycle: the target appears on instruction_addr at the edge after the qualifying cycle, with do_flush = 1 in the same cycle.
- misaligned is a 1-cycle pulse, aligned with its do_flush.
- A stalled cycle holds every output; jump/jalr presented during stall are dropped.
- Reset mid-stream: all state returns to reset values on the next edge, regardless of stall or trap.
- RAS push/pop takes effect at the edge; ras_top and ras_empty are registered views.

## Configuration
- PC_RAS_EN defined: return-address stack built, behaving as above.
- PC_RAS_EN undefined: no stack storage is built; is_call, is_return and link_addr are ignored; ras_top = 0 and ras_empty = 1 constantly. PC behaviour is unchanged.

## Test plan
- Reset with BOOT_ADDR = 0x100, run 3 free cycles -> instruction_addr 0x104, 0x108, 0x10C; ia_plus4 = addr+4; do_flush = 0.
- At PC 0x200, jump with offset 0xFFFF_FFF0 -> next PC 0x1F0, do_flush = 1 for one cycle, then 0 on the sequential step.
- jalr with jump_offset 0x301 -> PC 0x300. jalr with jump_offset 0x302 and trap_vector 0x80 -> PC 0x80, misaligned = 1 and do_flush = 1 for one cycle.
- Assert stall and jump together, then stall and trap to 0x40 -> the jump is dropped and PC holds; the trap is taken and PC = 0x40.
- PC at 0xFFFF_FFFC with XLEN = 32, sequential step -> PC 0x0000_0000.
- With PC_RAS_EN and RAS_DEPTH = 4: push 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_top = 0x50. Then pop 4 times -> tops 0x40, 0x30, 0x20, then ras_empty = 1. A further pop leaves ras_empty = 1. A simultaneous push 0x99 and pop on a one-entry stack -> top = 0x99, count = 1.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch program counter with redirect and optional return-address stack.
// Latency: redirects, flush and fault flags are registered and appear one cycle after the qualifying cycle.
// Backpressure: stall holds all state, and jump/jalr/RAS hints are dropped; trap and reset still act.
//
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   stall                 hold all state (trap and reset still act)
//   valid                 qualifies jump, jalr, is_call and is_return
//   jump, jalr            PC-relative / absolute redirect; jump_offset carries offset or target
//   trap, trap_vector     unconditional redirect to trap_vector
//   is_call, is_return    push link_addr / pop the return-address stack
//   link_addr             return address pushed on is_call
//   instruction_addr      current fetch address
//   ia_plus4              instruction_addr + 4 (registered alongside it)
//   do_flush              registered flush request
//   misaligned            registered misaligned-target fault pulse
//   ras_top, ras_empty    registered view of the return-address stack
//
// Build option: define PC_RAS_EN to build the return-address stack. Without it,
// the call/return inputs are ignored, ras_top = 0 and ras_empty = 1.

module pc_redirect_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] BOOT_ADDR = '0,
  parameter int unsigned     RAS_DEPTH = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            valid,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] jump_offset,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            is_call,
  input  logic            is_return,
  input  logic [XLEN-1:0] link_addr,
  output logic [XLEN-1:0] instruction_addr,
  output logic [XLEN-1:0] ia_plus4,
  output logic            do_flush,
  output logic            misaligned,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  // Redirect target selection; jump outranks jalr when both are presented.
  logic            take_jump;
  logic            take_jalr;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] redirect_target;

  assign take_jump       = valid & jump;
  assign take_jalr       = valid & jalr & ~jump;
  assign jump_target     = instruction_addr + jump_offset;
  assign jalr_target     = {jump_offset[XLEN-1:1], 1'b0};
  assign redirect_target = take_jump ? jump_target : jalr_target;

  logic [XLEN-1:0] pc_next;
  logic            flush_next;
  logic            misaligned_next;
  logic            pc_update;

  // trap overrides stall; otherwise a stalled cycle leaves every register alone.
  assign pc_update = trap | ~stall;

  always_comb begin
    pc_next         = instruction_addr + FOUR;
    flush_next      = 1'b0;
    misaligned_next = 1'b0;
    if (trap) begin
      pc_next    = trap_vector;
      flush_next = 1'b1;
    end else if (take_jump | take_jalr) begin
      flush_next = 1'b1;
      // A target with bit 1 set is not fetched; divert to the trap vector and flag it.
      if (redirect_target[1]) begin
        pc_next         = trap_vector;
        misaligned_next = 1'b1;
      end else begin
        pc_next = redirect_target;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instruction_addr <= BOOT_ADDR;
      ia_plus4         <= BOOT_ADDR + FOUR;
      do_flush         <= 1'b0;
      misaligned       <= 1'b0;
    end else if (pc_update) begin
      instruction_addr <= pc_next;
      ia_plus4         <= pc_next + FOUR;
      do_flush         <= flush_next;
      misaligned       <= misaligned_next;
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_en;
  logic             ras_push;
  logic             ras_pop;
  logic             ras_replace;

  assign ras_en      = valid & ~stall & ~trap;
  assign ras_push    = ras_en & is_call;
  // Popping an empty stack is a no-op.
  assign ras_pop     = ras_en & is_return & (ras_cnt != '0);
  // Call and return together swap the top entry in place.
  assign ras_replace = ras_push & ras_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_replace) begin
      ras_ptr <= ras_ptr;
      ras_cnt <= ras_cnt;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      // When full, the pointer wraps onto the oldest entry and the count saturates.
      if (ras_cnt != CNT_FULL) begin
        ras_cnt <= ras_cnt + CNT_W'(1);
      end
    end else if (ras_pop) begin
      ras_ptr <= ras_ptr - PTR_W'(1);
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only visible while the count covers them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (ras_replace) begin
        ras_mem[ras_ptr] <= link_addr;
      end else if (ras_push) begin
        ras_mem[ras_ptr + PTR_W'(1)] <= link_addr;
      end
    end
  end

  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_empty ? '0 : ras_mem[ras_ptr];
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = ^{is_call, is_return, link_addr};
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
`endif

endmodule
